tex_column_requester: RTL

- Initiator side of the texture lookup interface.
- Accepts one ray descriptor per screen column from the DDA/ray stage.
- Walks vcount over all SCREEN_HEIGHT rows of that column. For rows inside the wall slice it issues texture requests (valid, wallX, vcount, texture id) to the texture ROM block. It realigns the fixed-latency returned pixel with the row metadata.
- Emits one framebuffer write per row, filling non-wall rows with ceiling/floor colours.

---
 rtl/tex_column_requester.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/tex_column_requester.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module : tex_column_requester                                             |
// | Walks one screen column per ray. Wall rows fetch texels. Returned pixels  |
// | are realigned with row metadata, and one framebuffer write is made/row.   |
// | Option : define TEX_COLUMN_SHADE_EN to halve y-side wall pixels           |
// | Rev    : 1.0  initial release                                             |
// +---------------------------------------------------------------------------+
module tex_column_requester #(
  parameter int          SCREEN_WIDTH  = 320,
  parameter int          SCREEN_HEIGHT = 180,
  parameter int          TEX_LATENCY   = 2,
  parameter logic [15:0] CEIL_COLOR    = 16'h4208,
  parameter logic [15:0] FLOOR_COLOR   = 16'h8410,
  parameter logic [15:0] FLAT_COLOR    = 16'hF800
) (
  input  logic                             pixel_clk_in,
  input  logic                             rst_in,
  input  logic                             ray_valid_in,
  output logic                             ray_ready_out,
  input  logic [$clog2(SCREEN_WIDTH)-1:0]  ray_hcount_in,
  input  logic [15:0]                      ray_wallX_in,
  input  logic [3:0]                       ray_texture_in,
  input  logic [$clog2(SCREEN_HEIGHT)-1:0] ray_draw_start_in,
  input  logic [$clog2(SCREEN_HEIGHT)-1:0] ray_draw_end_in,
  input  logic                             ray_side_in,
  output logic                             tex_valid_req_out,
  output logic [15:0]                      tex_wallX_out,
  output logic [$clog2(SCREEN_HEIGHT)-1:0] tex_vcount_ray_out,
  output logic [3:0]                       tex_texture_out,
  input  logic [15:0]                      tex_pixel_in,
  output logic                             pix_valid_out,
  output logic [$clog2(SCREEN_WIDTH)-1:0]  pix_hcount_out,
  output logic [$clog2(SCREEN_HEIGHT)-1:0] pix_vcount_out,
  output logic [15:0]                      pix_data_out,
  output logic                             col_done_out
);

  localparam int c_HW = $clog2(SCREEN_WIDTH);
  localparam int c_VW = $clog2(SCREEN_HEIGHT);
  localparam int c_L  = TEX_LATENCY;
  localparam logic [c_VW-1:0] c_V_LAST = c_VW'(SCREEN_HEIGHT - 1);

  // Row class; bit 1 set means the row is part of the wall slice.
  localparam logic [1:0] c_K_CEIL  = 2'd0;
  localparam logic [1:0] c_K_FLOOR = 2'd1;
  localparam logic [1:0] c_K_FLAT  = 2'd2;
  localparam logic [1:0] c_K_TEX   = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          r_state;
  logic [c_VW-1:0] r_v;
  logic [c_VW-1:0] r_start;
  logic [c_VW-1:0] r_end;
  logic [c_HW-1:0] r_hcount;
  logic [15:0]     r_wallx;
  logic [3:0]      r_texture;

  logic            r_pv [0:c_L];
  logic [c_VW-1:0] r_pr [0:c_L];
  logic [1:0]      r_pk [0:c_L];

`ifdef TEX_COLUMN_SHADE_EN
  logic r_side;
  logic r_ps [0:c_L];
`else
  logic w_unused_side;
  assign w_unused_side = ray_side_in;
`endif

  logic [1:0]  w_kind;
  logic        w_pipe_busy;
  logic [15:0] w_base;
  logic [15:0] w_pix;

  always_comb begin
    w_kind = c_K_FLOOR;
    if (r_v < r_start)
      w_kind = c_K_CEIL;
    else if ((r_texture == 4'd0) || (r_v > r_end))
      w_kind = c_K_FLOOR;
    else if ((r_texture >= 4'd3) && (r_texture <= 4'd5))
      w_kind = c_K_TEX;
    else
      w_kind = c_K_FLAT;
  end

  // The last stage is excluded: its row is written on the same edge we leave DRAIN.
  always_comb begin
    w_pipe_busy = 1'b0;
    for (int i = 0; i < c_L; i++)
      w_pipe_busy = w_pipe_busy | r_pv[i];
  end

  always_comb begin
    case (r_pk[c_L])
      c_K_TEX:  w_base = tex_pixel_in;
      c_K_FLAT: w_base = FLAT_COLOR;
      c_K_CEIL: w_base = CEIL_COLOR;
      default:  w_base = FLOOR_COLOR;
    endcase
    w_pix = w_base;
`ifdef TEX_COLUMN_SHADE_EN
    if (r_ps[c_L] && r_pk[c_L][1])
      w_pix = {1'b0, w_base[15:1]} & 16'h7BEF;
`endif
  end

  always_ff @(posedge pixel_clk_in) begin
    if (!rst_in) begin
      r_state            <= IDLE;
      ray_ready_out      <= 1'b1;
      tex_valid_req_out  <= 1'b0;
      tex_wallX_out      <= '0;
      tex_vcount_ray_out <= '0;
      tex_texture_out    <= '0;
      pix_valid_out      <= 1'b0;
      pix_hcount_out     <= '0;
      pix_vcount_out     <= '0;
      pix_data_out       <= '0;
      col_done_out       <= 1'b0;
      r_v                <= '0;
      r_start            <= '0;
      r_end              <= '0;
      r_hcount           <= '0;
      r_wallx            <= '0;
      r_texture          <= '0;
      for (int i = 0; i <= c_L; i++) begin
        r_pv[i] <= 1'b0;
        r_pr[i] <= '0;
        r_pk[i] <= c_K_CEIL;
      end
`ifdef TEX_COLUMN_SHADE_EN
      r_side <= 1'b0;
      for (int i = 0; i <= c_L; i++) r_ps[i] <= 1'b0;
`endif
    end else begin
      for (int i = 1; i <= c_L; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pr[i] <= r_pr[i-1];
        r_pk[i] <= r_pk[i-1];
`ifdef TEX_COLUMN_SHADE_EN
        r_ps[i] <= r_ps[i-1];
`endif
      end
      r_pv[0]           <= 1'b0;
      tex_valid_req_out <= 1'b0;

      pix_valid_out <= r_pv[c_L];
      col_done_out  <= r_pv[c_L] && (r_pr[c_L] == c_V_LAST);
      if (r_pv[c_L]) begin
        pix_hcount_out <= r_hcount;
        pix_vcount_out <= r_pr[c_L];
        pix_data_out   <= w_pix;
      end

      case (r_state)
        IDLE: begin
          if (ray_valid_in) begin
            r_hcount      <= ray_hcount_in;
            r_wallx       <= ray_wallX_in;
            r_texture     <= ray_texture_in;
            r_start       <= ray_draw_start_in;
            r_end         <= ray_draw_end_in;
`ifdef TEX_COLUMN_SHADE_EN
            r_side        <= ray_side_in;
`endif
            r_v           <= '0;
            ray_ready_out <= 1'b0;
            r_state       <= FETCH;
          end
        end
        FETCH: begin
          r_pv[0] <= 1'b1;
          r_pr[0] <= r_v;
          r_pk[0] <= w_kind;
`ifdef TEX_COLUMN_SHADE_EN
          r_ps[0] <= r_side;
`endif
          if (w_kind == c_K_TEX) begin
            tex_valid_req_out  <= 1'b1;
            tex_wallX_out      <= r_wallx;
            tex_vcount_ray_out <= r_v;
            tex_texture_out    <= r_texture;
          end
          if (r_v == c_V_LAST)
            r_state <= DRAIN;
          else
            r_v <= r_v + 1'b1;
        end
        DRAIN: begin
          if (!w_pipe_busy) begin
            ray_ready_out <= 1'b1;
            r_state       <= IDLE;
          end
        end
        default: begin
          ray_ready_out <= 1'b1;
          r_state       <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
